led_blink_decoder: RTL and testbench



---
 rtl/led_blink_decoder_pkg.sv | 36 +++
 rtl/led_in_filter.sv | 46 ++++
 rtl/led_blink_decoder.sv | 139 +++++++++++++
 tb/tb_led_blink_decoder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_blink_decoder_pkg.sv
// Purpose : shared encodings and helpers for the LED blink decoder.
// Latency : n/a (types, constants and a combinational helper only).
// Backpres: n/a (no handshake; the decoder samples a free-running line).
package led_blink_decoder_pkg;

   // Width of the edge-to-edge interval counter.
   localparam int IVL_W = 27;

   // Decoded blink classification, as seen in BLINK_CODE.
   typedef enum logic [2:0] {
      BLK_NONE  = 3'd0,
      BLK_OFF   = 3'd1,
      BLK_ON    = 3'd2,
      BLK_1HZ   = 3'd3,
      BLK_2HZ   = 3'd4,
      BLK_4HZ   = 3'd5,
      BLK_IRREG = 3'd6
   } blink_code_t;

   // Measurement FSM states.
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_STEADY = 2'd2
   } dec_state_t;

   // True when an interval lies within +/-(nom >> tol_shift) of nom.
   function automatic logic in_band(input logic [IVL_W-1:0] ivl,
                                    input logic [IVL_W-1:0] nom,
                                    input int               tol_shift);
      logic [IVL_W-1:0] diff;
      diff = (ivl >= nom) ? (ivl - nom) : (nom - ivl);
      return (diff <= (nom >> tol_shift));
   endfunction

endpackage

// File: rtl/led_in_filter.sv
// Purpose : 2-flop synchronizer plus stability counter for the raw blink input.
// Latency : LED_IN to LED_FILT is FILT_CYC+2 SYSCLK cycles; EDGE_STB fires with the LED_FILT change.
// Backpres: none; pulses shorter than FILT_CYC synchronized cycles are dropped.
// Ports   : SYSCLK, RESET_N (async active-low), LED_IN (raw async),
//           LED_FILT (deglitched level), EDGE_STB (1-cycle pulse on each LED_FILT change).
module led_in_filter #(
   parameter int FILT_CYC = 16
) (
   input  logic SYSCLK,
   input  logic RESET_N,
   input  logic LED_IN,
   output logic LED_FILT,
   output logic EDGE_STB
);

   localparam int              CW   = $clog2(FILT_CYC + 1);
   localparam logic [CW-1:0]   LAST = CW'(FILT_CYC - 1);

   logic [1:0]    sync_q;
   logic [CW-1:0] stab_cnt;

   // sync_q[1] is the first metastability-safe copy of LED_IN.
   always_ff @(posedge SYSCLK or negedge RESET_N) begin
      if (!RESET_N) begin
         sync_q   <= 2'b00;
         stab_cnt <= '0;
         LED_FILT <= 1'b0;
         EDGE_STB <= 1'b0;
      end else begin
         sync_q   <= {sync_q[0], LED_IN};
         EDGE_STB <= 1'b0;
         if (sync_q[1] == LED_FILT) begin
            // Any return to the accepted level restarts the qualification.
            stab_cnt <= '0;
         end else if (stab_cnt == LAST) begin
            // This is the FILT_CYC-th consecutive differing cycle.
            LED_FILT <= sync_q[1];
            stab_cnt <= '0;
            EDGE_STB <= 1'b1;
         end else begin
            stab_cnt <= stab_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/led_blink_decoder.sv
// Purpose : classify an external blink line as off, on, 1/2/4 Hz or irregular.
// Latency : code commits 1 cycle after the MATCH_CNT-th matching filtered edge; steady after TMO+1 idle cycles.
// Backpres: none; free-running monitor, CODE_CHG is a 1-cycle pulse the cycle after BLINK_CODE moves.
// Ports   : SYSCLK, RESET_N (async active-low), LED_IN (raw blink input),
//           LED_FILT (deglitched input), BLINK_CODE[2:0] (blink_code_t), CODE_VLD (sticky), CODE_CHG (pulse).
module led_blink_decoder
   import led_blink_decoder_pkg::*;
#(
   parameter int CLK_FRQ   = 10_500_000,
   parameter int TOL_SHIFT = 3,
   parameter int MATCH_CNT = 4,
   parameter int FILT_CYC  = 16
) (
   input  logic       SYSCLK,
   input  logic       RESET_N,
   input  logic       LED_IN,
   output logic       LED_FILT,
   output logic [2:0] BLINK_CODE,
   output logic       CODE_VLD,
   output logic       CODE_CHG
);

   // Nominal half-periods and the no-edge timeout, all in SYSCLK cycles.
   localparam logic [IVL_W-1:0] H1  = IVL_W'(CLK_FRQ / 2);
   localparam logic [IVL_W-1:0] H2  = IVL_W'(CLK_FRQ / 4);
   localparam logic [IVL_W-1:0] H4  = IVL_W'(CLK_FRQ / 8);
   localparam logic [IVL_W-1:0] TMO = IVL_W'(CLK_FRQ + (CLK_FRQ >> 3));

   localparam int             MW        = $clog2(MATCH_CNT + 1);
   localparam logic [MW-1:0]  MATCH_MAX = MW'(MATCH_CNT);

   logic             edge_stb;
   dec_state_t       state;
   logic [IVL_W-1:0] ivl_cnt;
   blink_code_t      cand;
   logic [MW-1:0]    match_cnt;
   blink_code_t      code_q;
   blink_code_t      prev_code;
   blink_code_t      ivl_bin;
   logic [MW-1:0]    match_nxt;

   led_in_filter #(
      .FILT_CYC (FILT_CYC)
   ) u_filter (
      .SYSCLK   (SYSCLK),
      .RESET_N  (RESET_N),
      .LED_IN   (LED_IN),
      .LED_FILT (LED_FILT),
      .EDGE_STB (edge_stb)
   );

   assign BLINK_CODE = code_q;

   // Bin the interval that ends at the current edge and work out the
   // match count it would produce. Bands are disjoint for TOL_SHIFT >= 2.
   always_comb begin
      ivl_bin   = BLK_IRREG;
      match_nxt = MW'(1);
      if (in_band(ivl_cnt, H1, TOL_SHIFT)) begin
         ivl_bin = BLK_1HZ;
      end else if (in_band(ivl_cnt, H2, TOL_SHIFT)) begin
         ivl_bin = BLK_2HZ;
      end else if (in_band(ivl_cnt, H4, TOL_SHIFT)) begin
         ivl_bin = BLK_4HZ;
      end
      if (ivl_bin == cand) begin
         match_nxt = (match_cnt == MATCH_MAX) ? MATCH_MAX : (match_cnt + 1'b1);
      end
   end

   always_ff @(posedge SYSCLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state     <= S_IDLE;
         ivl_cnt   <= '0;
         cand      <= BLK_NONE;
         match_cnt <= '0;
         code_q    <= BLK_NONE;
         prev_code <= BLK_NONE;
         CODE_VLD  <= 1'b0;
         CODE_CHG  <= 1'b0;
      end else begin
         // Change detect one cycle behind the code register, so a
         // re-commit of the same value never pulses.
         prev_code <= code_q;
         CODE_CHG  <= (code_q != prev_code);

         // Interval counter: restarts at 1 on every edge, parks at TMO.
         if (edge_stb) begin
            ivl_cnt <= IVL_W'(1);
         end else if (ivl_cnt != TMO) begin
            ivl_cnt <= ivl_cnt + 1'b1;
         end

         case (state)
            S_IDLE: begin
               // First edge only opens a measurement window.
               if (edge_stb) begin
                  state <= S_RUN;
               end else if (ivl_cnt == TMO) begin
                  state     <= S_STEADY;
                  code_q    <= LED_FILT ? BLK_ON : BLK_OFF;
                  CODE_VLD  <= 1'b1;
                  cand      <= BLK_NONE;
                  match_cnt <= '0;
               end
            end
            S_RUN: begin
               // An edge landing on the timeout cycle is still an interval
               // (of length TMO, hence irregular) rather than a steady level.
               if (edge_stb) begin
                  cand      <= ivl_bin;
                  match_cnt <= match_nxt;
                  if (match_nxt == MATCH_MAX) begin
                     code_q   <= ivl_bin;
                     CODE_VLD <= 1'b1;
                  end
               end else if (ivl_cnt == TMO) begin
                  state     <= S_STEADY;
                  code_q    <= LED_FILT ? BLK_ON : BLK_OFF;
                  CODE_VLD  <= 1'b1;
                  cand      <= BLK_NONE;
                  match_cnt <= '0;
               end
            end
            S_STEADY: begin
               // The interval ending at this edge spans the steady period
               // and is not classified.
               if (edge_stb) begin
                  state <= S_RUN;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_led_blink_decoder.sv
// Purpose : directed, self-checking bench for led_blink_decoder with a code-change scoreboard.
// Latency : n/a.
// Backpres: n/a.
module tb_led_blink_decoder;

   localparam int FC  = 800;
   localparam int TS  = 3;
   localparam int MC  = 4;
   localparam int FL  = 4;
   localparam int TMO = FC + (FC >> 3);

   logic       SYSCLK;
   logic       RESET_N;
   logic       LED_IN;
   logic       LED_FILT;
   logic [2:0] BLINK_CODE;
   logic       CODE_VLD;
   logic       CODE_CHG;

   int checks;
   int errs;
   int cyc;
   int chg_cyc;
   int exp_q[$];

   led_blink_decoder #(
      .CLK_FRQ   (FC),
      .TOL_SHIFT (TS),
      .MATCH_CNT (MC),
      .FILT_CYC  (FL)
   ) dut (
      .SYSCLK     (SYSCLK),
      .RESET_N    (RESET_N),
      .LED_IN     (LED_IN),
      .LED_FILT   (LED_FILT),
      .BLINK_CODE (BLINK_CODE),
      .CODE_VLD   (CODE_VLD),
      .CODE_CHG   (CODE_CHG)
   );

   initial SYSCLK = 1'b0;
   always #5 SYSCLK = ~SYSCLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge SYSCLK);
   endtask

   // Toggle LED_IN n times, holding each level for p cycles.
   task automatic tog(input int n, input int p);
      repeat (n) begin
         LED_IN = ~LED_IN;
         wait_cyc(p);
      end
   endtask

   // Scoreboard: every CODE_CHG pulse must match the next expected code.
   // A pulse with nothing queued is compared against 0, which no real
   // change can produce.
   always @(negedge SYSCLK) begin
      int e;
      cyc++;
      if (CODE_CHG === 1'b1) begin
         e = 0;
         if (exp_q.size() > 0) e = exp_q.pop_front();
         chg_cyc = cyc;
         chk("chg_code", BLINK_CODE, e);
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int rel;
      int d;
      int n;
      logic lvl;
      checks  = 0;
      errs    = 0;
      cyc     = 0;
      chg_cyc = 0;

      // Reset state
      RESET_N = 1'b0;
      LED_IN  = 1'b0;
      wait_cyc(3);
      chk("rst_filt", LED_FILT, 0);
      chk("rst_code", BLINK_CODE, 0);
      chk("rst_vld", CODE_VLD, 0);
      chk("rst_chg", CODE_CHG, 0);

      // Steady low from reset -> code 1 after the timeout
      exp_q.push_back(1);
      RESET_N = 1'b1;
      rel = cyc;
      wait_cyc(1000);
      chk("off_code", BLINK_CODE, 1);
      chk("off_vld", CODE_VLD, 1);
      chk("off_chg_time", ((chg_cyc - rel) >= TMO) && ((chg_cyc - rel) <= TMO + 10), 1);
      chk("off_drained", exp_q.size(), 0);

      // 1 Hz: first edge measures filter latency, locks on 5th edge
      exp_q.push_back(3);
      LED_IN = 1'b1;
      d = 0;
      while (LED_FILT !== 1'b1 && d < 20) begin
         wait_cyc(1);
         d++;
      end
      chk("filt_latency", d, FL + 2);
      wait_cyc(400 - d);
      tog(3, 400);
      chk("1hz_not_yet", BLINK_CODE, 1);
      tog(1, 400);
      chk("1hz_code", BLINK_CODE, 3);
      chk("1hz_drained", exp_q.size(), 0);

      // 4 Hz: first 100-cycle toggle still closes a 400 interval
      exp_q.push_back(5);
      tog(4, 100);
      chk("4hz_not_yet", BLINK_CODE, 3);
      tog(1, 100);
      chk("4hz_code", BLINK_CODE, 5);
      chk("4hz_drained", exp_q.size(), 0);

      // 210/190 alternating stays inside the 2 Hz band
      exp_q.push_back(4);
      repeat (4) begin
         tog(1, 210);
         tog(1, 190);
      end
      chk("2hz_jitter_code", BLINK_CODE, 4);
      chk("2hz_drained", exp_q.size(), 0);

      // 230 is outside every band -> irregular
      exp_q.push_back(6);
      tog(4, 230);
      chk("irreg_not_yet", BLINK_CODE, 4);
      tog(1, 230);
      chk("irreg_code", BLINK_CODE, 6);
      chk("irreg_drained", exp_q.size(), 0);

      // 2 Hz lock, then a 3-cycle glitch mid-interval
      exp_q.push_back(4);
      tog(5, 200);
      chk("2hz_code", BLINK_CODE, 4);
      LED_IN = ~LED_IN;
      lvl = LED_IN;
      wait_cyc(100);
      LED_IN = ~lvl;
      wait_cyc(3);
      LED_IN = lvl;
      wait_cyc(8);
      chk("glitch_filt", LED_FILT, lvl);
      wait_cyc(89);
      tog(3, 200);
      chk("glitch_code", BLINK_CODE, 4);
      chk("glitch_drained", exp_q.size(), 0);

      // 1 Hz lock then hold high -> steady on TMO+1 after the filtered edge
      exp_q.push_back(3);
      n = (LED_IN === 1'b1) ? 5 : 6;
      tog(n, 400);
      chk("1hz_relock", BLINK_CODE, 3);
      exp_q.push_back(2);
      LED_IN = 1'b1;
      d = 0;
      while (LED_FILT !== 1'b1 && d < 20) begin
         wait_cyc(1);
         d++;
      end
      chk("hold_filt_rise", LED_FILT, 1);
      d = 0;
      while (BLINK_CODE !== 3'd2 && d < 1200) begin
         wait_cyc(1);
         d++;
      end
      chk("steady_on_latency", d, TMO + 1);
      wait_cyc(50);
      chk("on_drained", exp_q.size(), 0);

      // Resume 4 Hz: first edge discarded, lock on 5th edge
      exp_q.push_back(5);
      tog(4, 100);
      chk("resume_not_yet", BLINK_CODE, 2);
      tog(2, 100);
      chk("resume_code", BLINK_CODE, 5);
      chk("resume_drained", exp_q.size(), 0);

      // One-cycle reset mid-lock, then full relock
      if (LED_IN === 1'b1) tog(1, 100);
      wait_cyc(20);
      RESET_N = 1'b0;
      #1;
      chk("arst_code", BLINK_CODE, 0);
      chk("arst_vld", CODE_VLD, 0);
      chk("arst_filt", LED_FILT, 0);
      chk("arst_chg", CODE_CHG, 0);
      wait_cyc(1);
      RESET_N = 1'b1;
      exp_q.push_back(5);
      tog(4, 100);
      chk("relock_not_yet", BLINK_CODE, 0);
      chk("relock_vld_low", CODE_VLD, 0);
      tog(2, 100);
      chk("relock_code", BLINK_CODE, 5);
      chk("relock_vld", CODE_VLD, 1);
      chk("relock_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
